bus_fabric: RTL and testbench
=============================

// Module: bus_fabric
// PURPOSE
//  Parametrised single-master, N-slave bus interconnect between the core LSU and its peripherals.
//  Replaces fixed one-hot chip-select wiring. Adds:
//   - base/mask address decode
//   - per-slave ready handshake, giving variable wait states
//   - bus-error response on decode miss or slave timeout
//  Sits between execute's LSU port and the rom/mem/uart slaves.
// PARAMETERS
//  N_SLAVES  4                 number of slave ports, 1..16
//  ADDR_W    32                address width
//  DATA_W    32                data width
//  TIMEOUT   15                max ACCESS-state wait cycles before bus error, >=1
//  SLV_BASE  {N_SLAVES*ADDR_W} packed base addresses; slot k at [k*ADDR_W +: ADDR_W]
//                              default: 0x3000, 0x2000, 0x1000, 0x0000 (slot3..slot0)
//  SLV_MASK  {N_SLAVES*ADDR_W} packed compare masks
//                              default: 0xFFFFF000, 0xFFFFFFF0, 0xFFFFF000, 0xFFFFF000
// PORTS
//  clk_i      in   1                system clock, rising edge
//  rst_ni     in   1                asynchronous active-low reset
//  m_req_i    in   1                master request valid
//  m_we_i     in   1                1 = write, 0 = read
//  m_addr_i   in   ADDR_W           master address
//  m_wdata_i  in   DATA_W           master write data
//  m_hb_i     in   2                size: 00 word, 01 half, 10 byte
//  m_gnt_o    out  1                request accepted this cycle
//  m_rvalid_o out  1                response valid, one-cycle pulse
//  m_rdata_o  out  DATA_W           read data, valid with m_rvalid_o
//  m_err_o    out  1                bus error, valid with m_rvalid_o
//  s_cs_o     out  N_SLAVES         one-hot slave select
//  s_we_o     out  1                write enable to selected slave
//  s_addr_o   out  ADDR_W           registered address
//  s_wdata_o  out  DATA_W           registered write data
//  s_hb_o     out  2                registered size
//  s_rdata_i  in   N_SLAVES*DATA_W  packed slave read data; slot k at [k*DATA_W +: DATA_W]
//  s_ready_i  in   N_SLAVES         slave k completes access this cycle
// BEHAVIOUR
//  Reset (rst_ni low, asynchronous)
//   - FSM = IDLE; all outputs 0; wait counter 0.
//   - Mid-access reset aborts silently: no rvalid, s_cs_o drops immediately.
//  Decode
//   - Slot k hits when (m_addr_i & MASK[k]) == BASE[k].
//   - Lowest-index hit wins.
//  FSM states: IDLE, ACCESS, RESP.
//  IDLE
//   - m_gnt_o = m_req_i (combinational); requests are accepted only in IDLE.
//   - Accept with hit: register addr/wdata/we/hb and one-hot cs; clear counter; -> ACCESS.
//   - Accept with miss: s_cs_o stays 0; err_q=1, rdata_q=0; -> RESP.
//  ACCESS
//   - s_cs_o, s_we_o, s_addr_o, s_wdata_o, s_hb_o held stable.
//   - s_ready_i[sel] = 1: rdata_q = sel slave data (0 on writes), err_q = 0; drop cs; -> RESP.
//   - Else if counter == TIMEOUT-1: err_q = 1, rdata_q = 0; drop cs; -> RESP.
//   - Else counter++.
//   - s_ready_i from unselected slots is ignored.
//  RESP
//   - m_rvalid_o = 1 for exactly one cycle, with m_rdata_o/m_err_o; -> IDLE.
//   - m_gnt_o = 0 in RESP and ACCESS.
//  Latency (accept cycle = T)
//   - Hit, ready in T+1: rvalid at T+2.
//   - Each wait cycle adds 1.
//   - Timeout: rvalid at T+1+TIMEOUT.
//   - Decode miss: rvalid at T+1.
//  Back-to-back
//   - A new request may be accepted in the IDLE cycle following RESP.
//   - Minimum issue interval is 3 cycles.
//  Other rules
//   - m_rdata_o/m_err_o hold their last value between pulses.
//   - Counter width = $clog2(TIMEOUT+1).
// TESTING
//  1. Read 0x1004, RAM ready at T+1, data 0xDEADBEEF
//     -> s_cs_o=4'b0010 at T+1; rvalid at T+2, rdata 0xDEADBEEF, err 0.
//  2. Write 0x2000, wdata 0x41, UART ready after 3 wait cycles
//     -> cs/we/wdata held 4 cycles; rvalid at T+5, err 0.
//  3. Read 0x8000_0000 (no hit) -> s_cs_o stays 0; rvalid at T+1, err 1, rdata 0.
//  4. Read 0x0010, ROM never ready, TIMEOUT=15 -> rvalid at T+16, err 1; cs low from T+16.
//  5. Reset asserted at T+2 of a stalled access
//     -> all outputs 0 asynchronously, no rvalid; next request accepted normally.
//  6. m_req_i held high continuously -> m_gnt_o pulses every 3rd cycle; second request ignored until IDLE.

Source files
------------

// File: rtl/bus_fabric.sv
// Single-master, N-slave bus interconnect: base/mask decode, per-slave ready, bus error on miss/timeout.
// Latency: decode miss -> rvalid next cycle; hit -> rvalid two cycles after accept plus slave wait states.
// Backpressure: one transaction in flight; m_gnt_o is low outside IDLE, so new requests wait.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   m_req_i/m_we_i/m_addr_i/       master request, direction, address,
//   m_wdata_i/m_hb_i               write data and size (00 word, 01 half, 10 byte)
//   m_gnt_o                        request accepted this cycle (combinational, IDLE only)
//   m_rvalid_o/m_rdata_o/m_err_o   one-cycle response pulse; data/error hold between pulses
//   s_cs_o                         one-hot slave select, high only while accessing
//   s_we_o/s_addr_o/               registered write enable, address,
//   s_wdata_o/s_hb_o               write data and size
//   s_rdata_i/s_ready_i            packed slave read data and per-slave completion
module bus_fabric #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 15,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE =
        {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK =
        {32'hFFFF_F000, 32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_F000}
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         m_req_i,
    input  logic                         m_we_i,
    input  logic [ADDR_W-1:0]            m_addr_i,
    input  logic [DATA_W-1:0]            m_wdata_i,
    input  logic [1:0]                   m_hb_i,
    output logic                         m_gnt_o,
    output logic                         m_rvalid_o,
    output logic [DATA_W-1:0]            m_rdata_o,
    output logic                         m_err_o,
    output logic [N_SLAVES-1:0]          s_cs_o,
    output logic                         s_we_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W-1:0]            s_wdata_o,
    output logic [1:0]                   s_hb_o,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i,
    input  logic [N_SLAVES-1:0]          s_ready_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [N_SLAVES-1:0] cs_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          hb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic                hit;
    logic [N_SLAVES-1:0] hit_oh;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timed_out;

    // Scan from the top slot down so the lowest-index match is the last one written.
    always_comb begin
        hit    = 1'b0;
        hit_oh = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if ((m_addr_i & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
                hit       = 1'b1;
                hit_oh    = '0;
                hit_oh[k] = 1'b1;
            end
        end
    end

    // cs_q is one-hot while in ACCESS, so it doubles as the response mux select;
    // ready from any unselected slot is masked off here.
    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (cs_q[k]) begin
                sel_rdata = sel_rdata | s_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_ready = |(s_ready_i & cs_q);
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        m_gnt_o    = 1'b0;
        m_rvalid_o = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated with reset so the grant also reads 0 while reset is held.
                m_gnt_o = m_req_i & rst_ni;
                if (m_req_i) begin
                    state_d = hit ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (sel_ready || timed_out) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                m_rvalid_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            cs_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hb_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_req_i) begin
                        if (hit) begin
                            cs_q    <= hit_oh;
                            we_q    <= m_we_i;
                            addr_q  <= m_addr_i;
                            wdata_q <= m_wdata_i;
                            hb_q    <= m_hb_i;
                            cnt_q   <= '0;
                        end else begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        rdata_q <= we_q ? '0 : sel_rdata;
                        err_q   <= 1'b0;
                        cs_q    <= '0;
                        we_q    <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        cs_q    <= '0;
                        we_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_rdata_o = rdata_q;
    assign m_err_o   = err_q;
    assign s_cs_o    = cs_q;
    assign s_we_o    = we_q;
    assign s_addr_o  = addr_q;
    assign s_wdata_o = wdata_q;
    assign s_hb_o    = hb_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric with the default 4-slave map and TIMEOUT=15.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_bus_fabric;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         m_req, m_we;
    logic [31:0]  m_addr, m_wdata;
    logic [1:0]   m_hb;
    logic         m_gnt_o, m_rvalid_o, m_err_o;
    logic [31:0]  m_rdata_o;
    logic [3:0]   s_cs_o;
    logic         s_we_o;
    logic [31:0]  s_addr_o, s_wdata_o;
    logic [1:0]   s_hb_o;
    logic [127:0] s_rdata;
    logic [3:0]   s_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    bus_fabric dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .m_req_i    (m_req),
        .m_we_i     (m_we),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_hb_i     (m_hb),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .m_err_o    (m_err_o),
        .s_cs_o     (s_cs_o),
        .s_we_o     (s_we_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_hb_o     (s_hb_o),
        .s_rdata_i  (s_rdata),
        .s_ready_i  (s_ready)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_slave_data;
        s_rdata            = '0;
        s_rdata[0  +: 32]  = 32'h1111_1111;
        s_rdata[32 +: 32]  = 32'hDEAD_BEEF;
        s_rdata[64 +: 32]  = 32'hCAFE_F00D;
        s_rdata[96 +: 32]  = 32'h3333_3333;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1000; m_wdata = '0; m_hb = 2'b00;
        s_ready = '0;
        set_slave_data();
        #3;
        tests++; if (m_gnt_o !== 1'b0) begin fails++; $display("FAIL reset_gnt: got %b expected 0", m_gnt_o); end
        tests++; if (m_rvalid_o !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b expected 0", m_rvalid_o); end
        tests++; if (s_cs_o !== 4'b0000) begin fails++; $display("FAIL reset_cs: got %b expected 0000", s_cs_o); end
        tests++; if (m_rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", m_rdata_o); end
        tests++; if (m_err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", m_err_o); end
        tests++; if ({s_we_o, s_addr_o, s_wdata_o, s_hb_o} !== 67'h0) begin fails++; $display("FAIL reset_slave_side: got %h expected 0", {s_we_o, s_addr_o, s_wdata_o, s_hb_o}); end
        m_req = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // Read 0x1004 from slot 1, ready on the first access cycle.
    task automatic test_read;
        set_slave_data();
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_1004; m_hb = 2'b00;
        #1;
        tests++; if (m_gnt_o !== 1'b1) begin fails++; $display("FAIL read_gnt: got %b expected 1", m_gnt_o); end
        tick(); // T+1
        m_req = 1'b0;
        tests++; if (s_cs_o !== 4'b0010) begin fails++; $display("FAIL read_cs: got %b expected 0010", s_cs_o); end
        tests++; if (s_addr_o !== 32'h0000_1004) begin fails++; $display("FAIL read_addr: got %h expected 00001004", s_addr_o); end
        tests++; if (m_rvalid_o !== 1'b0) begin fails++; $display("FAIL read_early_rvalid: got %b expected 0", m_rvalid_o); end
        s_ready = 4'b0010;
        tick(); // T+2
        s_ready = 4'b0000;
        tests++; if (m_rvalid_o !== 1'b1) begin fails++; $display("FAIL read_rvalid: got %b expected 1", m_rvalid_o); end
        tests++; if (m_rdata_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL read_rdata: got %h expected deadbeef", m_rdata_o); end
        tests++; if (m_err_o !== 1'b0) begin fails++; $display("FAIL read_err: got %b expected 0", m_err_o); end
        tests++; if (s_cs_o !== 4'b0000) begin fails++; $display("FAIL read_cs_drop: got %b expected 0000", s_cs_o); end
        tick();
        tests++; if (m_rvalid_o !== 1'b0) begin fails++; $display("FAIL read_pulse_width: got %b expected 0", m_rvalid_o); end
        tests++; if (m_rdata_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL read_rdata_hold: got %h expected deadbeef", m_rdata_o); end
    endtask

    // Write 0x41 to UART at 0x2000, three wait cycles; unselected readies toggle meanwhile.
    task automatic test_write;
        set_slave_data();
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_2000; m_wdata = 32'h41; m_hb = 2'b10;
        #1;
        tests++; if (m_gnt_o !== 1'b1) begin fails++; $display("FAIL write_gnt: got %b expected 1", m_gnt_o); end
        tick();
        m_req = 1'b0; m_we = 1'b0; m_wdata = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            tests++; if ({s_cs_o, s_we_o, s_wdata_o, s_hb_o} !== {4'b0100, 1'b1, 32'h41, 2'b10}) begin fails++; $display("FAIL write_hold_%0d: got cs=%b we=%b wdata=%h hb=%b expected cs=0100 we=1 wdata=00000041 hb=10", i, s_cs_o, s_we_o, s_wdata_o, s_hb_o); end
            tests++; if (m_rvalid_o !== 1'b0) begin fails++; $display("FAIL write_wait_rvalid_%0d: got %b expected 0", i, m_rvalid_o); end
            s_ready = (i < 4) ? 4'b1011 : 4'b0100;
            tick();
        end
        s_ready = 4'b0000;
        tests++; if (m_rvalid_o !== 1'b1) begin fails++; $display("FAIL write_rvalid: got %b expected 1", m_rvalid_o); end
        tests++; if (m_err_o !== 1'b0) begin fails++; $display("FAIL write_err: got %b expected 0", m_err_o); end
        tests++; if (m_rdata_o !== 32'h0) begin fails++; $display("FAIL write_rdata: got %h expected 0", m_rdata_o); end
        tests++; if ({s_cs_o, s_we_o} !== 5'b0) begin fails++; $display("FAIL write_release: got cs=%b we=%b expected 0", s_cs_o, s_we_o); end
        tick();
    endtask

    // Decode misses: far address, and an address just outside the narrow UART mask.
    task automatic test_miss;
        logic [31:0] addrs [2];
        addrs[0] = 32'h8000_0000;
        addrs[1] = 32'h0000_2010;
        for (int i = 0; i < 2; i++) begin
            m_req = 1'b1; m_we = 1'b0; m_addr = addrs[i];
            #1;
            tests++; if (m_gnt_o !== 1'b1) begin fails++; $display("FAIL miss_gnt_%0d: got %b expected 1", i, m_gnt_o); end
            tick(); // T+1
            m_req = 1'b0;
            tests++; if (s_cs_o !== 4'b0000) begin fails++; $display("FAIL miss_cs_%0d: got %b expected 0000", i, s_cs_o); end
            tests++; if ({m_rvalid_o, m_err_o} !== 2'b11) begin fails++; $display("FAIL miss_resp_%0d: got rvalid=%b err=%b expected 1 1", i, m_rvalid_o, m_err_o); end
            tests++; if (m_rdata_o !== 32'h0) begin fails++; $display("FAIL miss_rdata_%0d: got %h expected 0", i, m_rdata_o); end
            tick();
            tests++; if ({m_rvalid_o, m_err_o} !== 2'b01) begin fails++; $display("FAIL miss_after_%0d: got rvalid=%b err=%b expected 0 1", i, m_rvalid_o, m_err_o); end
            if (i == 0) begin
                // Clear err/rdata with a good read before the second miss.
                test_read();
            end
        end
    endtask

    // ROM at 0x0010 never answers; other slots assert ready throughout.
    task automatic test_timeout;
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0010;
        #1;
        tests++; if (m_gnt_o !== 1'b1) begin fails++; $display("FAIL timeout_gnt: got %b expected 1", m_gnt_o); end
        tick();
        m_req = 1'b0;
        s_ready = 4'b1110;
        for (int i = 1; i <= 15; i++) begin
            tests++; if ({s_cs_o, m_rvalid_o} !== 5'b0001_0) begin fails++; $display("FAIL timeout_wait_%0d: got cs=%b rvalid=%b expected cs=0001 rvalid=0", i, s_cs_o, m_rvalid_o); end
            tick();
        end
        // T+16
        tests++; if ({m_rvalid_o, m_err_o} !== 2'b11) begin fails++; $display("FAIL timeout_resp: got rvalid=%b err=%b expected 1 1", m_rvalid_o, m_err_o); end
        tests++; if (m_rdata_o !== 32'h0) begin fails++; $display("FAIL timeout_rdata: got %h expected 0", m_rdata_o); end
        tests++; if (s_cs_o !== 4'b0000) begin fails++; $display("FAIL timeout_cs: got %b expected 0000", s_cs_o); end
        s_ready = 4'b0000;
        tick();
        tests++; if (m_rvalid_o !== 1'b0) begin fails++; $display("FAIL timeout_pulse: got %b expected 0", m_rvalid_o); end
    endtask

    // Reset two cycles into a stalled ROM access; err is still 1 from the timeout.
    task automatic test_reset_abort;
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0020; m_wdata = 32'h55; m_hb = 2'b01;
        #1;
        tick(); // T+1
        m_req = 1'b0; m_we = 1'b0; m_wdata = 32'h0; m_hb = 2'b00;
        tests++; if (s_cs_o !== 4'b0001) begin fails++; $display("FAIL abort_cs_before: got %b expected 0001", s_cs_o); end
        tick(); // T+2
        m_req = 1'b1;
        rst_ni = 1'b0;
        #1;
        tests++; if (s_cs_o !== 4'b0000) begin fails++; $display("FAIL abort_cs: got %b expected 0000", s_cs_o); end
        tests++; if ({s_we_o, s_addr_o, s_wdata_o, s_hb_o} !== 67'h0) begin fails++; $display("FAIL abort_slave_side: got %h expected 0", {s_we_o, s_addr_o, s_wdata_o, s_hb_o}); end
        tests++; if ({m_gnt_o, m_rvalid_o, m_err_o} !== 3'b000) begin fails++; $display("FAIL abort_master_side: got gnt=%b rvalid=%b err=%b expected 0 0 0", m_gnt_o, m_rvalid_o, m_err_o); end
        m_req = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++; if ({m_rvalid_o, s_cs_o} !== 5'b0) begin fails++; $display("FAIL abort_quiet_%0d: got rvalid=%b cs=%b expected 0", i, m_rvalid_o, s_cs_o); end
            tick();
        end
        test_read();
    endtask

    // Request held high with RAM always ready: grant every third cycle.
    task automatic test_back_to_back;
        set_slave_data();
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_1008;
        s_ready = 4'b0010;
        #1;
        for (int i = 0; i < 9; i++) begin
            tests++; if (m_gnt_o !== (i % 3 == 0)) begin fails++; $display("FAIL b2b_gnt_%0d: got %b expected %b", i, m_gnt_o, (i % 3 == 0)); end
            tests++; if (m_rvalid_o !== (i % 3 == 2)) begin fails++; $display("FAIL b2b_rvalid_%0d: got %b expected %b", i, m_rvalid_o, (i % 3 == 2)); end
            tests++; if (s_cs_o !== ((i % 3 == 1) ? 4'b0010 : 4'b0000)) begin fails++; $display("FAIL b2b_cs_%0d: got %b expected %b", i, s_cs_o, ((i % 3 == 1) ? 4'b0010 : 4'b0000)); end
            tick();
            #1;
        end
        m_req = 1'b0;
        s_ready = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_read();
        test_miss();
        test_read();
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
